// File: rtl/block_counter4bit_up.sv
// ============================================================================
// Module   : block_counter4bit_up
// Brief    : Prescaled 4-bit up-counter (0..MAX_COUNT) with load, enable and
//            cascadable one-cycle Tick/Carry strobes. Define the macro
//            BLOCK_COUNTER4BIT_UP_SEG7_EN to add a registered 7-segment output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_counter4bit_up #(
    parameter int CLK_DIV   = 50000000,
    parameter int MAX_COUNT = 15
) (
    input  logic       clk_50M,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Load,
    input  logic [3:0] LoadValue,
    output logic [3:0] Output,
    output logic       Tick,
    output logic       Carry
`ifdef BLOCK_COUNTER4BIT_UP_SEG7_EN
    ,
    output logic [6:0] Seg
`endif
);

    localparam int               c_PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(CLK_DIV - 1);
    localparam logic [3:0]        c_MAX     = 4'(MAX_COUNT);

    generate
        if (CLK_DIV < 1 || MAX_COUNT < 1 || MAX_COUNT > 15) begin : g_param_check
            $error("block_counter4bit_up: CLK_DIV or MAX_COUNT out of range");
        end
    endgenerate

    logic [c_PS_W-1:0] r_ps;
    logic [3:0]        r_count;
    logic              r_tick;
    logic              r_carry;

    logic [c_PS_W-1:0] w_ps_next;
    logic [3:0]        w_count_next;
    logic              w_tick_next;
    logic              w_carry_next;
    logic              w_step;

    assign w_step = Enable && (r_ps == c_PS_LAST);

    // Load wins over a coincident step; the step is simply lost.
    always_comb begin
        w_ps_next    = r_ps;
        w_count_next = r_count;
        w_tick_next  = 1'b0;
        w_carry_next = 1'b0;
        if (Load) begin
            w_ps_next    = '0;
            w_count_next = (LoadValue > c_MAX) ? c_MAX : LoadValue;
        end else if (Enable) begin
            w_ps_next = w_step ? '0 : r_ps + c_PS_W'(1);
            if (w_step) begin
                w_tick_next = 1'b1;
                if (r_count == c_MAX) begin
                    w_count_next = 4'd0;
                    w_carry_next = 1'b1;
                end else begin
                    w_count_next = r_count + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (Reset) begin
            r_ps    <= '0;
            r_count <= 4'd0;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_ps    <= w_ps_next;
            r_count <= w_count_next;
            r_tick  <= w_tick_next;
            r_carry <= w_carry_next;
        end
    end

    assign Output = r_count;
    assign Tick   = r_tick;
    assign Carry  = r_carry;

`ifdef BLOCK_COUNTER4BIT_UP_SEG7_EN
    localparam logic [6:0] c_SEG_ZERO = 7'b1000000;

    // Active-low segments, bit order g..a.
    function automatic logic [6:0] f_hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [6:0] r_seg;

    // Decoding the next count keeps Seg aligned with Output in every cycle.
    always_ff @(posedge clk_50M) begin
        if (Reset) begin
            r_seg <= c_SEG_ZERO;
        end else begin
            r_seg <= f_hex_to_seg(w_count_next);
        end
    end

    assign Seg = r_seg;
`endif

endmodule

`default_nettype wire

// File: tb/tb_block_counter4bit_up.sv
// ============================================================================
// Module   : tb_block_counter4bit_up
// Brief    : Self-checking bench for block_counter4bit_up (CLK_DIV=4/MAX=9 and
//            CLK_DIV=1/MAX=15 instances sharing one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_counter4bit_up;

    localparam int c_DIV_A = 4;
    localparam int c_MAX_A = 9;
    localparam int c_DIV_B = 1;
    localparam int c_MAX_B = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] out_a, out_b;
    logic       tick_a, tick_b, carry_a, carry_b;
`ifdef BLOCK_COUNTER4BIT_UP_SEG7_EN
    logic [6:0] seg_a, seg_b;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: count value plus number of enabled cycles spent in the
    // current prescale period.
    int ma_out, ma_ph, ma_tick, ma_carry;
    int mb_out, mb_ph, mb_tick, mb_carry;

    always #10 clk = ~clk;

    block_counter4bit_up #(.CLK_DIV(c_DIV_A), .MAX_COUNT(c_MAX_A)) u_dut_a (
        .clk_50M   (clk),
        .Reset     (rst),
        .Enable    (en),
        .Load      (ld),
        .LoadValue (lv),
        .Output    (out_a),
        .Tick      (tick_a),
        .Carry     (carry_a)
`ifdef BLOCK_COUNTER4BIT_UP_SEG7_EN
        ,
        .Seg       (seg_a)
`endif
    );

    block_counter4bit_up #(.CLK_DIV(c_DIV_B), .MAX_COUNT(c_MAX_B)) u_dut_b (
        .clk_50M   (clk),
        .Reset     (rst),
        .Enable    (en),
        .Load      (ld),
        .LoadValue (lv),
        .Output    (out_b),
        .Tick      (tick_b),
        .Carry     (carry_b)
`ifdef BLOCK_COUNTER4BIT_UP_SEG7_EN
        ,
        .Seg       (seg_b)
`endif
    );

`ifdef BLOCK_COUNTER4BIT_UP_SEG7_EN
    function automatic logic [6:0] hex7(input int v);
        logic [6:0] tab [16];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tab[v];
    endfunction
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int div, input int maxc, input bit r, input bit e,
                              input bit l, input int v,
                              inout int mo, inout int mph, inout int mt, inout int mc);
        mt = 0;
        mc = 0;
        if (r) begin
            mo  = 0;
            mph = 0;
        end else if (l) begin
            mo  = (v > maxc) ? maxc : v;
            mph = 0;
        end else if (e) begin
            mph = mph + 1;
            if (mph == div) begin
                mph = 0;
                mt  = 1;
                mc  = (mo == maxc) ? 1 : 0;
                mo  = (mo + 1) % (maxc + 1);
            end
        end
    endtask

    // Apply one cycle of inputs, advance both models, then settle before checks.
    task automatic cyc(input bit r, input bit e, input bit l, input int v);
        rst = r;
        en  = e;
        ld  = l;
        lv  = 4'(v);
        @(posedge clk);
        model_step(c_DIV_A, c_MAX_A, r, e, l, v, ma_out, ma_ph, ma_tick, ma_carry);
        model_step(c_DIV_B, c_MAX_B, r, e, l, v, mb_out, mb_ph, mb_tick, mb_carry);
        #1;
    endtask

    typedef struct packed {
        bit       r;
        bit       e;
        bit       l;
        logic [3:0] v;
        logic [3:0] o;
        bit       t;
        bit       c;
    } vec_t;

    vec_t tbl [15];

    initial begin
        rst = 1'b1; en = 1'b0; ld = 1'b0; lv = 4'd0;
        ma_out = 0; ma_ph = 0; ma_tick = 0; ma_carry = 0;
        mb_out = 0; mb_ph = 0; mb_tick = 0; mb_carry = 0;

        //          r  e  l  v   out t  c
        tbl[0]  = '{1, 0, 0, 0,  0,  0, 0};
        tbl[1]  = '{1, 0, 0, 0,  0,  0, 0};
        tbl[2]  = '{0, 1, 0, 0,  0,  0, 0};
        tbl[3]  = '{0, 1, 0, 0,  0,  0, 0};
        tbl[4]  = '{0, 1, 0, 0,  0,  0, 0};
        tbl[5]  = '{0, 1, 0, 0,  1,  1, 0};
        tbl[6]  = '{0, 1, 1, 13, 9,  0, 0};
        tbl[7]  = '{0, 1, 0, 0,  9,  0, 0};
        tbl[8]  = '{0, 1, 0, 0,  9,  0, 0};
        tbl[9]  = '{0, 1, 0, 0,  9,  0, 0};
        tbl[10] = '{0, 1, 0, 0,  0,  1, 1};
        tbl[11] = '{0, 0, 0, 0,  0,  0, 0};
        tbl[12] = '{0, 0, 1, 7,  7,  0, 0};
        tbl[13] = '{0, 0, 1, 15, 9,  0, 0};
        tbl[14] = '{0, 0, 1, 0,  0,  0, 0};

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].r, tbl[i].e, tbl[i].l, int'(tbl[i].v));
            check($sformatf("tbl%0d_out", i), out_a, tbl[i].o);
            check($sformatf("tbl%0d_tick", i), tick_a, tbl[i].t);
            check($sformatf("tbl%0d_carry", i), carry_a, tbl[i].c);
        end

        // Full run from reset: one step every 4 cycles, wrap 9->0 at cycle 40.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 1, 0, 0);
            check("run_out", out_a, (i / 4) % 10);
            check("run_tick", tick_a, (i % 4 == 0) ? 1 : 0);
            check("run_carry", carry_a, (i == 40) ? 1 : 0);
        end

        // Freeze mid-period at Output=3 with two enabled cycles already spent.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 14; i++) cyc(0, 1, 0, 0);
        check("frz_pre_out", out_a, 3);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0);
            check("frz_hold_out", out_a, 3);
            check("frz_hold_tick", tick_a, 0);
        end
        cyc(0, 1, 0, 0);
        check("frz_re1_out", out_a, 3);
        cyc(0, 1, 0, 0);
        check("frz_re2_out", out_a, 4);
        check("frz_re2_tick", tick_a, 1);

        // Load on a step cycle drops the step and restarts the period.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 7);
        check("ldstep_out", out_a, 7);
        check("ldstep_tick", tick_a, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            check("ldstep_wait_out", out_a, 7);
        end
        cyc(0, 1, 0, 0);
        check("ldstep_next_out", out_a, 8);
        check("ldstep_next_tick", tick_a, 1);

        // Reset mid-period discards partial prescale.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 22; i++) cyc(0, 1, 0, 0);
        check("rstmid_pre_out", out_a, 5);
        cyc(1, 1, 0, 0);
        check("rstmid_out", out_a, 0);
        check("rstmid_tick", tick_a, 0);
        check("rstmid_carry", carry_a, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            check("rstmid_wait_out", out_a, 0);
        end
        cyc(0, 1, 0, 0);
        check("rstmid_step_out", out_a, 1);
        check("rstmid_step_tick", tick_a, 1);

        // CLK_DIV=1 instance: steps every enabled cycle, carry every 16.
        cyc(1, 0, 0, 0);
`ifdef BLOCK_COUNTER4BIT_UP_SEG7_EN
        check("b_seg_reset", seg_b, 7'b1000000);
`endif
        for (int i = 1; i <= 33; i++) begin
            cyc(0, 1, 0, 0);
            check("b_out", out_b, i % 16);
            check("b_tick", tick_b, 1);
            check("b_carry", carry_b, (i % 16 == 0) ? 1 : 0);
`ifdef BLOCK_COUNTER4BIT_UP_SEG7_EN
            if (i % 16 == 15) check("b_seg_f", seg_b, 7'b0001110);
`endif
        end

        // Random traffic against the reference model for both instances.
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)));
            check("rnd_a_out", out_a, ma_out);
            check("rnd_a_tick", tick_a, ma_tick);
            check("rnd_a_carry", carry_a, ma_carry);
            check("rnd_b_out", out_b, mb_out);
            check("rnd_b_tick", tick_b, mb_tick);
            check("rnd_b_carry", carry_b, mb_carry);
`ifdef BLOCK_COUNTER4BIT_UP_SEG7_EN
            check("rnd_a_seg", seg_a, hex7(ma_out));
            check("rnd_b_seg", seg_b, hex7(mb_out));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
